panel_scan: RTL and testbench

PANEL_SCAN -- requirements
Module: panel_scan

---
 rtl/panel_scan.sv | 174 +++++++++++++++++
 tb/tb_panel_scan.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_scan.sv
// rtl/panel_scan.sv - HUB75-style LED panel scan controller with binary PWM phase sweep
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   enable                : run request, sampled in IDLE and at the end of each line
//   pwm, fb_row, col_addr : framebuffer/comparator addressing (registered)
//   r0..b1                : comparator results for col_addr of the previous cycle
//   panel_r0..panel_b1    : registered panel shift data
//   panel_clk, panel_lat  : panel shift clock and latch strobe
//   panel_oe_n            : panel output enable, active-low
//   panel_row             : row address presented to the panel
//   frame_start           : one-cycle pulse on the first shift cycle of a PWM frame

module panel_scan #(
    parameter int PWM_WIDTH   = 8,
    parameter int COL_BITS    = 5,
    parameter int ROW_BITS    = 4,
    parameter int DISP_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    output logic [PWM_WIDTH-1:0] pwm,
    output logic [ROW_BITS-1:0]  fb_row,
    output logic [COL_BITS-1:0]  col_addr,
    input  logic                 r0,
    input  logic                 g0,
    input  logic                 b0,
    input  logic                 r1,
    input  logic                 g1,
    input  logic                 b1,
    output logic                 panel_r0,
    output logic                 panel_g0,
    output logic                 panel_b0,
    output logic                 panel_r1,
    output logic                 panel_g1,
    output logic                 panel_b1,
    output logic                 panel_clk,
    output logic                 panel_lat,
    output logic                 panel_oe_n,
    output logic [ROW_BITS-1:0]  panel_row,
    output logic                 frame_start
);

    localparam int DW = $clog2(DISP_CYCLES + 1);
    localparam logic [DW-1:0] DISP_LAST = DW'(DISP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_TAIL,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t               state, state_nxt;
    // Shift cycle index: upper bits are the column, bit 0 selects fetch/hold half.
    logic [COL_BITS:0]    shift_cnt, shift_cnt_nxt;
    logic [DW-1:0]        disp_cnt, disp_cnt_nxt;
    logic [ROW_BITS-1:0]  fb_row_nxt;
    logic [PWM_WIDTH-1:0] pwm_nxt;

    logic [COL_BITS-1:0]  col_addr_nxt;
    logic                 panel_clk_nxt;
    logic                 panel_lat_nxt;
    logic                 panel_oe_n_nxt;
    logic                 frame_start_nxt;

    always_comb begin
        state_nxt     = state;
        shift_cnt_nxt = shift_cnt;
        disp_cnt_nxt  = disp_cnt;
        fb_row_nxt    = fb_row;
        pwm_nxt       = pwm;

        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_nxt     = S_SHIFT;
                    shift_cnt_nxt = '0;
                end
            end
            S_SHIFT: begin
                if (shift_cnt == '1) begin
                    state_nxt = S_TAIL;
                end else begin
                    shift_cnt_nxt = shift_cnt + 1'b1;
                end
            end
            S_TAIL:  state_nxt = S_BLANK;
            S_BLANK: state_nxt = S_LATCH;
            S_LATCH: begin
                state_nxt    = S_DISPLAY;
                disp_cnt_nxt = '0;
            end
            S_DISPLAY: begin
                if (disp_cnt == DISP_LAST) begin
                    fb_row_nxt = fb_row + 1'b1;
                    if (fb_row == '1) begin
                        pwm_nxt = pwm + 1'b1;
                    end
                    shift_cnt_nxt = '0;
                    state_nxt     = enable ? S_SHIFT : S_IDLE;
                end else begin
                    disp_cnt_nxt = disp_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Outputs are decoded from the next state so that, once registered,
        // they line up with the state they belong to.
        col_addr_nxt    = (state_nxt == S_SHIFT) ? shift_cnt_nxt[COL_BITS:1] : '0;
        // Rising panel_clk on even cycles clocks the column captured two cycles
        // earlier; TAIL supplies the final edge for the last column.
        panel_clk_nxt   = (state_nxt == S_TAIL) ||
                          ((state_nxt == S_SHIFT) && !shift_cnt_nxt[0] &&
                           (shift_cnt_nxt[COL_BITS:1] != '0));
        panel_lat_nxt   = (state_nxt == S_LATCH);
        panel_oe_n_nxt  = (state_nxt != S_DISPLAY);
        // shift_cnt_nxt == 0 inside SHIFT only happens on the entry cycle.
        frame_start_nxt = (state_nxt == S_SHIFT) && (shift_cnt_nxt == '0) &&
                          (fb_row_nxt == '0) && (pwm_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            shift_cnt   <= '0;
            disp_cnt    <= '0;
            fb_row      <= '0;
            pwm         <= '0;
            col_addr    <= '0;
            panel_clk   <= 1'b0;
            panel_lat   <= 1'b0;
            panel_oe_n  <= 1'b1;
            frame_start <= 1'b0;
            panel_row   <= '0;
            panel_r0    <= 1'b0;
            panel_g0    <= 1'b0;
            panel_b0    <= 1'b0;
            panel_r1    <= 1'b0;
            panel_g1    <= 1'b0;
            panel_b1    <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift_cnt   <= shift_cnt_nxt;
            disp_cnt    <= disp_cnt_nxt;
            fb_row      <= fb_row_nxt;
            pwm         <= pwm_nxt;
            col_addr    <= col_addr_nxt;
            panel_clk   <= panel_clk_nxt;
            panel_lat   <= panel_lat_nxt;
            panel_oe_n  <= panel_oe_n_nxt;
            frame_start <= frame_start_nxt;

            // Comparator data for column c is valid in the hold half (odd cycle).
            if ((state == S_SHIFT) && shift_cnt[0]) begin
                panel_r0 <= r0;
                panel_g0 <= g0;
                panel_b0 <= b0;
                panel_r1 <= r1;
                panel_g1 <= g1;
                panel_b1 <= b1;
            end

            if (state == S_LATCH) begin
                panel_row <= fb_row;
            end
        end
    end

endmodule

// File: tb/tb_panel_scan.sv
// tb/tb_panel_scan.sv - self-checking bench for panel_scan with a line-level reference model

module tb_panel_scan;

    localparam int PW   = 2;
    localparam int CB   = 2;
    localparam int RB   = 1;
    localparam int DC   = 4;
    localparam int COLS = 1 << CB;
    localparam int ROWS = 1 << RB;
    localparam int LINE = 2 * COLS + 3 + DC;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] pwm;
    logic [RB-1:0] fb_row;
    logic [CB-1:0] col_addr;
    logic          r0 = 1'b0, g0 = 1'b0, b0 = 1'b0, r1 = 1'b0, g1 = 1'b0, b1 = 1'b0;
    logic          panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1;
    logic          panel_clk, panel_lat, panel_oe_n, frame_start;
    logic [RB-1:0] panel_row;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    int line_no;

    logic [5:0] pix [ROWS][COLS];

    panel_scan #(
        .PWM_WIDTH  (PW),
        .COL_BITS   (CB),
        .ROW_BITS   (RB),
        .DISP_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pwm        (pwm),
        .fb_row     (fb_row),
        .col_addr   (col_addr),
        .r0         (r0),
        .g0         (g0),
        .b0         (b0),
        .r1         (r1),
        .g1         (g1),
        .b1         (b1),
        .panel_r0   (panel_r0),
        .panel_g0   (panel_g0),
        .panel_b0   (panel_b0),
        .panel_r1   (panel_r1),
        .panel_g1   (panel_g1),
        .panel_b1   (panel_b1),
        .panel_clk  (panel_clk),
        .panel_lat  (panel_lat),
        .panel_oe_n (panel_oe_n),
        .panel_row  (panel_row),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Comparator with one cycle of latency from col_addr to its outputs.
    always @(posedge clk) begin
        {r0, g0, b0, r1, g1, b1} <= pix[fb_row][col_addr];
    end

    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            assert (!(panel_lat && !panel_oe_n) && !(panel_clk && (panel_lat || !panel_oe_n)))
            else begin
                bad++;
                $error("FAIL strobe_overlap observed clk=%0b lat=%0b oe_n=%0b expected no lat/clk while oe_n=0",
                       panel_clk, panel_lat, panel_oe_n);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected test completion");
        $fatal(1, "watchdog");
    end

    task automatic check_reset(input string tag);
        logic [15:0] obs;
        logic [15:0] exp;
        obs = {pwm, fb_row, col_addr, panel_row,
               panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1,
               panel_clk, panel_lat, frame_start, panel_oe_n};
        exp = 16'h0001;
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n, input int row, input int pw);
        logic [6:0] obs;
        logic [6:0] exp;
        for (int i = 0; i < n; i++) begin
            obs = {panel_clk, panel_lat, panel_oe_n, frame_start, fb_row, pwm};
            exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'(row), 2'(pw)};
            total++;
            assert (obs === exp)
            else begin
                bad++;
                $error("FAIL idle i=%0d observed=%b expected=%b", i, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    // Checks one line starting at its first SHIFT cycle. drop_at/rst_at give the
    // line cycle after which enable is dropped or reset is asserted (-1 = never).
    task automatic run_line(input int row, input int pw, input int drop_at, input int rst_at);
        logic [6:0] obs;
        logic [6:0] exp;
        logic [5:0] dat;
        logic       e_clk, e_lat, e_oe, e_fs;
        for (int t = 0; t < LINE; t++) begin
            e_clk = ((t < 2 * COLS) && (t % 2 == 0) && (t > 0)) || (t == 2 * COLS);
            e_lat = (t == 2 * COLS + 2);
            e_oe  = (t < 2 * COLS + 3);
            e_fs  = (t == 0) && (row == 0) && (pw == 0);
            obs = {panel_clk, panel_lat, panel_oe_n, frame_start, fb_row, pwm};
            exp = {e_clk, e_lat, e_oe, e_fs, 1'(row), 2'(pw)};
            total++;
            assert (obs === exp)
            else begin
                bad++;
                $error("FAIL line_ctl row=%0d pwm=%0d t=%0d observed=%b expected=%b", row, pw, t, obs, exp);
            end
            if (t < 2 * COLS) begin
                total++;
                assert (col_addr === 2'(t / 2))
                else begin
                    bad++;
                    $error("FAIL col_addr t=%0d observed=%0d expected=%0d", t, col_addr, t / 2);
                end
            end
            if (e_clk) begin
                dat = {panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1};
                total++;
                assert (dat === pix[row][t / 2 - 1])
                else begin
                    bad++;
                    $error("FAIL panel_data row=%0d col=%0d observed=%b expected=%b",
                           row, t / 2 - 1, dat, pix[row][t / 2 - 1]);
                end
            end
            if (!e_oe) begin
                total++;
                assert (panel_row === 1'(row))
                else begin
                    bad++;
                    $error("FAIL panel_row t=%0d observed=%0d expected=%0d", t, panel_row, row);
                end
            end
            if (t == drop_at) enable = 1'b0;
            if (t == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset("reset_async");
                return;
            end
            @(negedge clk);
        end
    endtask

    function automatic int row_of(input int n);
        return n % ROWS;
    endfunction

    function automatic int pwm_of(input int n);
        return (n / ROWS) % (1 << PW);
    endfunction

    initial begin
        int drop;

        // Red upper channel mirrors column parity; remaining channels random.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                pix[r][c] = {1'(c % 2), 5'($urandom)};

        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset_state");

        mon_en = 1'b1;
        rst_n  = 1'b1;
        idle_cycles(3, 0, 0);

        enable = 1'b1;
        @(negedge clk);

        // Full frame plus the first line of the next one.
        line_no = 0;
        for (int n = 0; n < ROWS * (1 << PW) + 1; n++) begin
            run_line(row_of(line_no), pwm_of(line_no), -1, -1);
            line_no++;
        end

        // Random pixels and random enable drops during SHIFT.
        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    pix[r][c] = 6'($urandom);
            if (k == 0) drop = 3;
            else if ($urandom_range(0, 1) == 1) drop = int'($urandom_range(0, 2 * COLS - 1));
            else drop = -1;
            run_line(row_of(line_no), pwm_of(line_no), drop, -1);
            line_no++;
            if (drop >= 0) begin
                idle_cycles(int'($urandom_range(1, 4)), row_of(line_no), pwm_of(line_no));
                enable = 1'b1;
                @(negedge clk);
            end
        end

        // Reset in the middle of DISPLAY, then restart from row 0 / pwm 0.
        run_line(row_of(line_no), pwm_of(line_no), -1, 2 * COLS + 4);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        line_no = 0;
        for (int n = 0; n < 3; n++) begin
            run_line(row_of(line_no), pwm_of(line_no), -1, -1);
            line_no++;
        end

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
